result_quant_ctrl: RTL

RESULT_QUANT_CTRL -- requirements
Module: result_quant_ctrl

---
 rtl/result_quant_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/result_quant_ctrl.sv
// result_quant_ctrl: moves finished psum tiles from the core
// through the quantizer and into the output buffer, one layer at a time.
module result_quant_ctrl #(
   parameter int ADDR_WIDTH   = 10,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cfg_Vld,
   output logic                  cfg_Rdy,
   input  logic [4:0]            cfg_Layer,
   input  logic [1:0]            cfg_Prec,
   input  logic [2:0]            cfg_Shift,
   input  logic [ADDR_WIDTH-1:0] cfg_NumTiles,
   input  logic [ADDR_WIDTH-1:0] cfg_Base,
   input  logic                  core_Done,
   output logic                  core_Stall,
   output logic                  q_Vld_i,
   output logic [4:0]            q_Layer,
   output logic [1:0]            q_Prec,
   output logic [2:0]            q_Shift,
   input  logic                  q_Vld_o,
   input  logic                  wr_Full,
   output logic                  wr_En,
   output logic [ADDR_WIDTH-1:0] wr_Addr,
   output logic                  layer_Done,
   output logic                  busy,
   output logic [2:0]            err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] INFL_MAX = 4'(MAX_INFLIGHT);
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] num_tiles;
   logic [ADDR_WIDTH-1:0] issued;
   logic [ADDR_WIDTH-1:0] returned;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0]            inflight;
   logic [4:0]            layer;
   logic [1:0]            prec;
   logic [2:0]            shift;
   logic [2:0]            err_q;

   logic st_idle;
   logic st_run;
   logic st_active;
   logic st_done;
   logic cfg_take;
   logic stall;
   logic issue;
   logic ret_ok;
   logic ret_bad;
   logic last_issue;
   logic drain_done;

   // state decode
   always_comb begin
      st_idle   = (state == ST_IDLE);
      st_run    = (state == ST_RUN);
      st_active = (state == ST_RUN) | (state == ST_DRAIN);
      st_done   = (state == ST_DONE);
   end

   // issue and return qualification; reset masks every strobe
   always_comb begin
      stall      = RST
                 | ~st_run
                 | (inflight == INFL_MAX)
                 | wr_Full
                 | (issued == num_tiles);
      issue      = core_Done & ~stall;
      ret_ok     = q_Vld_o & st_active & ~RST;
      ret_bad    = q_Vld_o & ~st_active & ~RST;
      cfg_take   = cfg_Vld & st_idle;
      last_issue = issue & ((issued + ONE) == num_tiles);
      drain_done = (returned == num_tiles)
                 | (ret_ok & ((returned + ONE) == num_tiles));
   end

   // next-state selection
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (cfg_Vld) begin
               if (cfg_NumTiles == '0) state_nxt = ST_DONE;
               else                    state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_issue) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_done) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // latched layer configuration, held until the next accepted cfg
   always_ff @(posedge CLK) begin
      if (RST) begin
         layer     <= '0;
         prec      <= '0;
         shift     <= '0;
         num_tiles <= '0;
      end else if (cfg_take) begin
         layer     <= cfg_Layer;
         prec      <= cfg_Prec;
         shift     <= cfg_Shift;
         num_tiles <= cfg_NumTiles;
      end
   end

   // issued / returned tile counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         issued   <= '0;
         returned <= '0;
      end else if (cfg_take) begin
         issued   <= '0;
         returned <= '0;
      end else begin
         if (issue)  issued   <= issued + ONE;
         if (ret_ok) returned <= returned + ONE;
      end
   end

   // tiles sitting in the quantizer; a simultaneous issue and return cancel
   always_ff @(posedge CLK) begin
      if (RST) begin
         inflight <= '0;
      end else if (cfg_take) begin
         inflight <= '0;
      end else begin
         case ({issue, ret_ok})
            2'b10: inflight <= inflight + 4'd1;
            2'b01: begin
               if (inflight != 4'd0) inflight <= inflight - 4'd1;
            end
            default: inflight <= inflight;
         endcase
      end
   end

   // output-buffer write pointer, wraps at 2^ADDR_WIDTH
   always_ff @(posedge CLK) begin
      if (RST)           addr <= '0;
      else if (cfg_take) addr <= cfg_Base;
      else if (ret_ok)   addr <= addr + ONE;
   end

   // sticky error flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= '0;
      end else begin
         if (ret_ok & wr_Full)    err_q[0] <= 1'b1;
         if (ret_bad)             err_q[1] <= 1'b1;
         if (cfg_Vld & ~st_idle)  err_q[2] <= 1'b1;
      end
   end

   assign cfg_Rdy    = st_idle;
   assign core_Stall = stall;
   assign q_Vld_i    = issue;
   assign q_Layer    = layer;
   assign q_Prec     = prec;
   assign q_Shift    = shift;
   assign wr_En      = ret_ok;
   assign wr_Addr    = addr;
   assign layer_Done = st_done & ~RST;
   assign busy       = ~st_idle & ~RST;
   assign err        = err_q;

endmodule
